// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch stage.
package mips_pkg;

  localparam int          IF_ADDR_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]          instr;
    logic [IF_ADDR_W-1:0] pc4;
    logic                 valid;
  } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats load, otherwise holds.
import mips_pkg::*;

module ifid_reg #(
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  logic  flush_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t bubble;
  ifid_t ifid_q;

  assign bubble = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_q <= bubble;
    end else if (flush_i) begin
      ifid_q <= bubble;
    end else if (load_i) begin
      ifid_q <= d_i;
    end
  end

  assign q_o = ifid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: fetches the word at PC, fills IF/ID, and stalls the PC via fetch_wait.
// state | meaning
// IDLE  | latch PC as next fetch address, no request
// REQ   | request outstanding, address held until ack
// FULL  | fetched word parked in holding buffer, waiting for the pipe to advance
import mips_pkg::*;

module instr_fetch_unit #(
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC,
  input  logic              datastall,
  input  logic              controlstall,
  input  logic              branch_enable,
  input  logic              jump_enable,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              ifid_valid,
  output logic              fetch_wait
);

  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              kill_q, kill_d;
  ifid_t             buf_q, buf_d;
  ifid_t             ifid_d, ifid_q;
  logic              ifid_load;
  logic              redirect, advance;
  logic [ADDR_W-1:0] pc_al, pc_al4, addr4;

  assign redirect = branch_enable | jump_enable;
  assign advance  = datastall & controlstall & ~redirect;
  assign pc_al    = {PC[ADDR_W-1:2], 2'b00};
  assign pc_al4   = pc_al + FOUR;
  assign addr4    = addr_q + FOUR;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      kill_q  <= 1'b0;
      buf_q   <= '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    kill_d    = kill_q;
    buf_d     = buf_q;
    ifid_load = 1'b0;
    ifid_d    = buf_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        addr_d  = pc_al;
      end
      REQ: begin
        if (imem_ack) begin
          kill_d = 1'b0;
          if (kill_q || redirect) begin
            addr_d = pc_al;
          end else if (advance) begin
            ifid_load = 1'b1;
            ifid_d    = '{instr: imem_rdata, pc4: addr4, valid: 1'b1};
            addr_d    = pc_al4;
          end else begin
            buf_d   = '{instr: imem_rdata, pc4: addr4, valid: 1'b1};
            state_d = FULL;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      FULL: begin
        if (redirect) begin
          state_d = REQ;
          addr_d  = pc_al;
        end else if (advance) begin
          // PC still points at the buffered word; it steps past it this edge
          ifid_load = 1'b1;
          state_d   = REQ;
          addr_d    = pc_al4;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ifid_load),
    .flush_i (redirect),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign fetch_wait = ~ifid_load;
  assign ifid_instr = ifid_q.instr;
  assign ifid_pc4   = ifid_q.pc4;
  assign ifid_valid = ifid_q.valid;

endmodule
